fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream synchronous FIFO and
// serializes them as 8N1 or 8E1 frames, LSB first, with a registered tx line.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  // state  | meaning
  // IDLE   | line high, pop the FIFO when it holds data
  // FETCH  | capture FIFO read data into the shift register
  // START  | start bit (low)
  // DATA   | 8 data bits, LSB first
  // PARITY | even parity bit (PARITY_EN=1 only)
  // STOP   | stop bit (high), frame_done on its last cycle

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_bit, par_bit_nxt;
  logic          tx_nxt;
  logic          baud_last;

  assign baud_last  = (baud_cnt == BAUD_LAST);
  // Gated by rst so a FIFO holding data is never popped while in reset.
  assign fifo_rd_en = rst && (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && baud_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_bit_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + CW'(1);
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    par_bit_nxt  = par_bit;
    tx_nxt       = 1'b1;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (fifo_rd_en) state_nxt = FETCH;
      end
      FETCH: begin
        baud_cnt_nxt = '0;
        shreg_nxt    = fifo_data;
        par_bit_nxt  = ^fifo_data;
        state_nxt    = START;
      end
      START: begin
        if (baud_last) begin
          baud_cnt_nxt = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_nxt = '0;
          shreg_nxt    = {1'b0, shreg[7:1]};
          bit_idx_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (baud_last) begin
          baud_cnt_nxt = '0;
          state_nxt    = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // tx follows the next state so the registered line lines up with the state.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_bit_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E1) each fed by a
// behavioural 8-entry FIFO; frames are decoded off tx and compared to push order.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty [2] = '{1'b1, 1'b1};
  logic [7:0] fifo_data  [2] = '{8'h00, 8'h00};
  logic       fifo_rd_en [2];
  logic       tx         [2];
  logic       busy       [2];
  logic       frame_done [2];

  logic       wr_en   [2] = '{1'b0, 1'b0};
  logic [7:0] wr_data [2] = '{8'h00, 8'h00};
  logic [7:0] mem [2][8];
  int         cnt [2], rd_p [2], pops [2], underflow [2], rd_cyc [2];
  bit         pend_pop [2], do_pop [2], do_push [2];
  logic [7:0] d_in [2];
  int         cyc = 0;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  // Upstream FIFO: pop/push on the rising edge, registered read data and flag.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      pend_pop[1'(c)] = (fifo_rd_en[1'(c)] === 1'b1);
      if (fifo_rd_en[1'(c)] === 1'b1) begin
        rd_cyc[1'(c)] = cyc;
        if (fifo_empty[1'(c)]) underflow[1'(c)]++;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < 2; c++) begin
      do_pop[1'(c)]  = pend_pop[1'(c)] && (rst === 1'b1);
      do_push[1'(c)] = wr_en[1'(c)];
      d_in[1'(c)]    = wr_data[1'(c)];
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      if (do_pop[1'(c)] && cnt[1'(c)] > 0) begin
        fifo_data[1'(c)] = mem[1'(c)][3'(rd_p[1'(c)])];
        rd_p[1'(c)] = (rd_p[1'(c)] + 1) % 8;
        cnt[1'(c)]--;
        pops[1'(c)]++;
      end
      if (do_push[1'(c)] && cnt[1'(c)] < 8) begin
        mem[1'(c)][3'((rd_p[1'(c)] + cnt[1'(c)]) % 8)] = d_in[1'(c)];
        cnt[1'(c)]++;
      end
      fifo_empty[1'(c)] = (cnt[1'(c)] == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic push_seq(input bit ch, input logic [7:0] bs [$]);
    foreach (bs[i]) begin
      @(negedge clk);
      wr_en[ch] = 1'b1;
      wr_data[ch] = bs[i];
    end
    @(negedge clk);
    wr_en[ch] = 1'b0;
  endtask

  task automatic push(input bit ch, input logic [7:0] b);
    logic [7:0] q [$];
    q.push_back(b);
    push_seq(ch, q);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Decodes one frame off tx sampled at negedges; reports shape, no judgement.
  task automatic grab(input bit ch, input int tmo, output bit found, output logic [7:0] data,
                      output logic par, output bit clean, output int fd_n, output int fd_at,
                      output int fd_cyc, output int busy_n, output int wait_n);
    int nb;
    logic [10:0] bits;
    nb = (10 + int'(ch)) * CPB;
    found = 1'b0; wait_n = 0; busy_n = 0; fd_n = 0; fd_at = -1; fd_cyc = -1; bits = '1;
    while (!found && wait_n < tmo) begin
      @(negedge clk);
      if (tx[ch] === 1'b0) found = 1'b1;
      else begin
        wait_n++;
        if (busy[ch] === 1'b1) busy_n++;
      end
    end
    clean = found;
    if (found) begin
      for (int i = 0; i < nb; i++) begin
        if (i > 0) @(negedge clk);
        if (i % CPB == 0) bits[4'(i / CPB)] = tx[ch];
        else if (tx[ch] !== bits[4'(i / CPB)]) clean = 1'b0;
        if (frame_done[ch] === 1'b1) begin fd_n++; fd_at = i; fd_cyc = cyc; end
        if (busy[ch] === 1'b1) busy_n++;
      end
      if (bits[0] !== 1'b0 || bits[4'(nb / CPB - 1)] !== 1'b1) clean = 1'b0;
    end
    data = bits[8:1];
    par  = bits[9];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({tx[1'(c)], busy[1'(c)], frame_done[1'(c)], fifo_rd_en[1'(c)]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_outputs ch%0d got tx/busy/done/rd=%b%b%b%b exp 1000", c,
                 tx[1'(c)], busy[1'(c)], frame_done[1'(c)], fifo_rd_en[1'(c)]);
      end
    end
    release_rst();
  endtask

  task automatic test_idle_empty();
    int p0, p1;
    p0 = pops[0]; p1 = pops[1];
    repeat (100) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        checks++;
        if ({fifo_rd_en[1'(c)], tx[1'(c)], busy[1'(c)], frame_done[1'(c)]} !== 4'b0100) begin
          errors++;
          $display("FAIL idle_empty ch%0d got rd/tx/busy/done=%b%b%b%b exp 0100", c,
                   fifo_rd_en[1'(c)], tx[1'(c)], busy[1'(c)], frame_done[1'(c)]);
        end
      end
    end
    checks++;
    if (pops[0] - p0 + pops[1] - p1 !== 0) begin
      errors++;
      $display("FAIL idle_pops got %0d exp 0", pops[0] - p0 + pops[1] - p1);
    end
  endtask

  task automatic test_single_8n1();
    bit found, clean;
    logic [7:0] data;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, p0;
    logic [7:0] b;
    b = 8'hA5;
    p0 = pops[0];
    push(1'b0, b);
    grab(1'b0, 20, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL single_found got %b exp 1", found); end
    checks++; if (data !== b) begin errors++; $display("FAIL single_data got %h exp %h", data, b); end
    checks++; if (clean !== 1'b1) begin errors++; $display("FAIL single_shape got %b exp 1", clean); end
    checks++; if (fd_n !== 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", fd_n); end
    checks++; if (fd_at !== 10 * CPB - 1) begin errors++; $display("FAIL single_done_pos got %0d exp %0d", fd_at, 10 * CPB - 1); end
    // FETCH plus the ten bit cells; the pop cycle itself is still IDLE
    checks++; if (busy_n !== 10 * CPB + 1) begin errors++; $display("FAIL single_busy got %0d exp %0d", busy_n, 10 * CPB + 1); end
    checks++; if (fd_cyc - rd_cyc[0] + 1 !== 10 * CPB + 2) begin
      errors++; $display("FAIL single_span got %0d exp %0d", fd_cyc - rd_cyc[0] + 1, 10 * CPB + 2);
    end
    checks++; if (pops[0] - p0 !== 1) begin errors++; $display("FAIL single_pops got %0d exp 1", pops[0] - p0); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({tx[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL single_after got tx/busy=%b%b exp 10", tx[0], busy[0]); end
    end
  endtask

  task automatic test_parity();
    bit found, clean;
    logic [7:0] data;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, prev_fd;
    logic [7:0] bs [$];
    bs.push_back(8'hA5);
    bs.push_back(8'h07);
    push_seq(1'b1, bs);
    prev_fd = -1;
    foreach (bs[i]) begin
      grab(1'b1, 20, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL parity_found[%0d] got %b exp 1", i, found); end
      checks++; if (data !== bs[i]) begin errors++; $display("FAIL parity_data[%0d] got %h exp %h", i, data, bs[i]); end
      checks++; if (par !== ^bs[i]) begin errors++; $display("FAIL parity_bit[%0d] got %b exp %b", i, par, ^bs[i]); end
      checks++; if (clean !== 1'b1) begin errors++; $display("FAIL parity_shape[%0d] got %b exp 1", i, clean); end
      checks++; if (fd_at !== 11 * CPB - 1) begin errors++; $display("FAIL parity_done_pos[%0d] got %0d exp %0d", i, fd_at, 11 * CPB - 1); end
      if (i > 0) begin
        checks++; if (wait_n !== 2) begin errors++; $display("FAIL parity_gap got %0d exp 2", wait_n); end
        checks++; if (fd_cyc - prev_fd !== 11 * CPB + 2) begin
          errors++; $display("FAIL parity_period got %0d exp %0d", fd_cyc - prev_fd, 11 * CPB + 2);
        end
      end
      prev_fd = fd_cyc;
    end
  endtask

  task automatic test_same_cycle_write();
    bit found, clean;
    logic [7:0] data;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, p0;
    logic [7:0] bs [$];
    bs.push_back(8'h11);
    bs.push_back(8'h55);
    p0 = pops[0];
    push_seq(1'b0, bs);
    checks++; if (cnt[0] !== 1) begin errors++; $display("FAIL samecyc_count got %0d exp 1", cnt[0]); end
    foreach (bs[i]) begin
      grab(1'b0, 20, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
      checks++; if (data !== bs[i]) begin errors++; $display("FAIL samecyc_data[%0d] got %h exp %h", i, data, bs[i]); end
      checks++; if (clean !== 1'b1) begin errors++; $display("FAIL samecyc_shape[%0d] got %b exp 1", i, clean); end
    end
    repeat (3) @(negedge clk);
    checks++; if (pops[0] - p0 !== 2) begin errors++; $display("FAIL samecyc_pops got %0d exp 2", pops[0] - p0); end
    checks++; if (cnt[0] !== 0) begin errors++; $display("FAIL samecyc_left got %0d exp 0", cnt[0]); end
  endtask

  task automatic test_full_burst();
    bit found, clean;
    logic [7:0] data;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, p0, prev_fd;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b0, 8'(i));
    checks++; if (cnt[0] !== 8) begin errors++; $display("FAIL burst_fill got %0d exp 8", cnt[0]); end
    checks++; if (fifo_rd_en[0] !== 1'b0) begin errors++; $display("FAIL burst_rd_in_reset got %b exp 0", fifo_rd_en[0]); end
    p0 = pops[0];
    prev_fd = -1;
    release_rst();
    for (int i = 0; i < 8; i++) begin
      grab(1'b0, 20, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
      checks++; if (data !== 8'(i)) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", i, data, 8'(i)); end
      checks++; if (clean !== 1'b1) begin errors++; $display("FAIL burst_shape[%0d] got %b exp 1", i, clean); end
      if (i > 0) begin
        checks++; if (fd_cyc - prev_fd !== 10 * CPB + 2) begin
          errors++; $display("FAIL burst_period[%0d] got %0d exp %0d", i, fd_cyc - prev_fd, 10 * CPB + 2);
        end
      end
      prev_fd = fd_cyc;
    end
    repeat (5) @(negedge clk);
    checks++; if (pops[0] - p0 !== 8) begin errors++; $display("FAIL burst_pops got %0d exp 8", pops[0] - p0); end
    checks++; if (cnt[0] !== 0) begin errors++; $display("FAIL burst_left got %0d exp 0", cnt[0]); end
    checks++; if (underflow[0] !== 0) begin errors++; $display("FAIL burst_underflow got %0d exp 0", underflow[0]); end
  endtask

  task automatic test_mid_reset();
    bit found, clean;
    logic [7:0] data, b;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, p0, n;
    b = 8'h3C;
    push(1'b0, b);
    n = 0;
    while (tx[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (tx[0] !== 1'b0) begin errors++; $display("FAIL midrst_start got %b exp 0", tx[0]); end
    repeat (4 * CPB + 1) @(negedge clk);
    checks++; if (tx[0] !== b[3]) begin errors++; $display("FAIL midrst_bit3 got %b exp %b", tx[0], b[3]); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({tx[0], busy[0], fifo_rd_en[0]} !== 3'b100) begin
      errors++; $display("FAIL midrst_abort got tx/busy/rd=%b%b%b exp 100", tx[0], busy[0], fifo_rd_en[0]);
    end
    push(1'b0, 8'h5A);
    p0 = pops[0];
    release_rst();
    grab(1'b0, 20, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL midrst_next_data got %h exp 5a", data); end
    checks++; if (clean !== 1'b1) begin errors++; $display("FAIL midrst_next_shape got %b exp 1", clean); end
    checks++; if (pops[0] - p0 !== 1) begin errors++; $display("FAIL midrst_pops got %0d exp 1", pops[0] - p0); end
  endtask

  task automatic test_random(input bit ch);
    bit found, clean;
    logic [7:0] data, e, b;
    logic par;
    int fd_n, fd_at, fd_cyc, busy_n, wait_n, n;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 60)) @(negedge clk);
          n = 0;
          while (cnt[ch] >= 8 && n < 2000) begin @(negedge clk); n++; end
          b = 8'($urandom);
          push(ch, b);
          exp_q.push_back(b);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          grab(ch, 3000, found, data, par, clean, fd_n, fd_at, fd_cyc, busy_n, wait_n);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++; if (found !== 1'b1) begin errors++; $display("FAIL rand_found ch%0d[%0d] got %b exp 1", ch, i, found); end
          checks++; if (data !== e) begin errors++; $display("FAIL rand_data ch%0d[%0d] got %h exp %h", ch, i, data, e); end
          checks++; if (clean !== 1'b1 || fd_n !== 1) begin
            errors++; $display("FAIL rand_shape ch%0d[%0d] got shape=%b done=%0d exp 1/1", ch, i, clean, fd_n);
          end
          if (ch) begin
            checks++; if (par !== ^e) begin errors++; $display("FAIL rand_parity[%0d] got %b exp %b", i, par, ^e); end
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (underflow[ch] !== 0) begin errors++; $display("FAIL rand_underflow ch%0d got %0d exp 0", ch, underflow[ch]); end
    checks++; if ({tx[ch], busy[ch]} !== 2'b10) begin errors++; $display("FAIL rand_idle ch%0d got tx/busy=%b%b exp 10", ch, tx[ch], busy[ch]); end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single_8n1();
    test_parity();
    test_same_cycle_write();
    test_full_burst();
    test_mid_reset();
    test_random(1'b0);
    test_random(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
